// File: rtl/rate_counter_pair.sv
// Slow/fast up-down counter pair driven from a single clock, with a prescaler tick,
// a registered slow square wave and terminal-count pulses. Define COUNT_SAT_EN to saturate instead of wrap.
module rate_counter_pair #(
  parameter int WIDTH = 3,
  parameter int DIV   = 4
) (
  input  logic             clk_f,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       x,
  input  logic             up_dn,
  output logic             tick_s,
  output logic             clk_s,
  output logic [WIDTH-1:0] count_s,
  output logic [WIDTH-1:0] count_f,
  output logic             tc_s,
  output logic             tc_f
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_SLOW = 2'b00,
    MODE_FAST = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [PRE_W-1:0] pre_cnt;
  mode_e            mode;
  logic             step_s, step_f;
  logic             bound_s, bound_f;
  logic [WIDTH-1:0] next_s, next_f;
  logic             pre_wrap;

  assign mode     = mode_e'(x);
  assign pre_wrap = (pre_cnt == PRE_LAST);

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    step_s  = tick_s && (mode == MODE_SLOW || mode == MODE_BOTH);
    step_f  = (mode == MODE_FAST || mode == MODE_BOTH);
    bound_s = up_dn ? (count_s == COUNT_MAX) : (count_s == '0);
    bound_f = up_dn ? (count_f == COUNT_MAX) : (count_f == '0);
    next_s  = count_s;
    next_f  = count_f;
`ifdef COUNT_SAT_EN
    // A blocked step at the bound leaves the count where it is.
    if (step_s && !bound_s) next_s = up_dn ? count_s + 1'b1 : count_s - 1'b1;
    if (step_f && !bound_f) next_f = up_dn ? count_f + 1'b1 : count_f - 1'b1;
`else
    // Modulo-2^WIDTH arithmetic gives the wrap for free.
    if (step_s) next_s = up_dn ? count_s + 1'b1 : count_s - 1'b1;
    if (step_f) next_f = up_dn ? count_f + 1'b1 : count_f - 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_f or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      tick_s  <= 1'b0;
      clk_s   <= 1'b0;
      count_s <= '0;
      count_f <= '0;
      tc_s    <= 1'b0;
      tc_f    <= 1'b0;
    end else if (clr) begin
      // clk_s deliberately keeps its phase across a clear.
      pre_cnt <= '0;
      tick_s  <= 1'b0;
      count_s <= '0;
      count_f <= '0;
      tc_s    <= 1'b0;
      tc_f    <= 1'b0;
    end else begin
      if (pre_wrap) begin
        pre_cnt <= '0;
        tick_s  <= 1'b1;
        clk_s   <= ~clk_s;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
        tick_s  <= 1'b0;
      end
      count_s <= next_s;
      count_f <= next_f;
      tc_s    <= step_s && bound_s;
      tc_f    <= step_f && bound_f;
    end
  end

endmodule
